// File: rtl/gpio_pkg.sv
// Register map, FSM state encoding and timing constants shared by the
// GPIO interrupt-servicing Avalon-MM master.
package gpio_pkg;

    localparam int REG_DATA     = 0;
    localparam int REG_ENABLE   = 4;
    localparam int REG_IRQ_MASK = 8;
    localparam int REG_IRQ_POL  = 12;
    localparam int REG_IRQ_ACK  = 16;

    // Idle cycles after the ack write so the responder's registered ack
    // has cleared irq before it is sampled again.
    localparam int GUARD_CYCLES = 2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_EN    = 4'd1,
        ST_WR_MASK  = 4'd2,
        ST_WR_POL   = 4'd3,
        ST_WAIT_IRQ = 4'd4,
        ST_RD_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_GUARD    = 4'd7,
        ST_EVT_OUT  = 4'd8
    } master_state_t;

    function automatic logic is_bus_state(master_state_t s);
        return s inside {ST_WR_EN, ST_WR_MASK, ST_WR_POL, ST_RD_DATA, ST_WR_ACK};
    endfunction

endpackage

// File: rtl/avm_xfer.sv
// Single Avalon-MM transfer engine: holds strobe/address/data until the
// responder accepts, and aborts a transfer stalled for 2^TMO_W-1 cycles.
module avm_xfer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              timeout,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    // The stalled cycle that fires the timeout is the one the counter would
    // advance to all-ones, so the strobe is high for exactly 2^TMO_W-1 stalls.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic              strobe_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;

    assign done          = strobe_reg && !avm_waitrequest;
    assign timeout       = strobe_reg && avm_waitrequest && (tmo_cnt_reg == TMO_LAST);
    assign rdata         = avm_readdata;
    assign avm_address   = addr_reg;
    assign avm_writedata = wdata_reg;
    assign avm_write     = strobe_reg && rw_reg;
    assign avm_read      = strobe_reg && !rw_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_reg  <= 1'b0;
            rw_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            tmo_cnt_reg <= '0;
        end else if (req) begin
            strobe_reg  <= 1'b1;
            rw_reg      <= rw;
            addr_reg    <= addr;
            wdata_reg   <= wdata;
            tmo_cnt_reg <= '0;
        end else if (done || timeout) begin
            strobe_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
        end else if (strobe_reg) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_irq_master.sv
// Configures a register-mapped GPIO responder, then services each interrupt
// (read data, ack, guard) and forwards the captured word on a valid/ready port.
module gpio_irq_master
    import gpio_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [DATA_W-1:0] cfg_enable,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic [DATA_W-1:0] cfg_pol,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              irq_i,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_data,
    input  logic              evt_ready,
    output logic              busy,
    output logic              err_timeout
);

    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    master_state_t      state_reg, state_next;
    logic [DATA_W-1:0]  mask_reg, pol_reg, evt_data_reg;
    logic               evt_valid_reg, err_timeout_reg, stop_pend_reg;
    logic [GUARD_W-1:0] guard_cnt_reg;
    logic               guard_last, stop_now;

    logic              req, req_rw, x_done, x_timeout;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata, x_rdata;

    assign guard_last = (guard_cnt_reg == GUARD_W'(GUARD_CYCLES - 1));
    assign stop_now   = cfg_stop || stop_pend_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (cfg_start) state_next = ST_WR_EN;
            ST_WR_EN:    if (x_timeout) state_next = ST_IDLE;
                         else if (x_done) state_next = stop_now ? ST_IDLE : ST_WR_MASK;
            ST_WR_MASK:  if (x_timeout) state_next = ST_IDLE;
                         else if (x_done) state_next = stop_now ? ST_IDLE : ST_WR_POL;
            ST_WR_POL:   if (x_timeout) state_next = ST_IDLE;
                         else if (x_done) state_next = stop_now ? ST_IDLE : ST_WAIT_IRQ;
            ST_WAIT_IRQ: if (stop_now) state_next = ST_IDLE;
                         else if (irq_i) state_next = ST_RD_DATA;
            // A stop seen during the read still finishes the ack so the
            // responder is never left with an unacknowledged interrupt.
            ST_RD_DATA:  if (x_timeout) state_next = ST_IDLE;
                         else if (x_done) state_next = ST_WR_ACK;
            ST_WR_ACK:   if (x_timeout) state_next = ST_IDLE;
                         else if (x_done) state_next = ST_GUARD;
            ST_GUARD:    if (guard_last) state_next = stop_now ? ST_IDLE : ST_EVT_OUT;
            ST_EVT_OUT:  if (stop_now) state_next = ST_IDLE;
                         else if (evt_ready) state_next = ST_WAIT_IRQ;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Launch the transfer on the edge that enters a bus state, so each bus
    // state costs a single cycle when the responder does not stall.
    always_comb begin
        req       = 1'b0;
        req_rw    = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        if (state_next != state_reg) begin
            case (state_next)
                ST_WR_EN:   begin req = 1'b1; req_addr = ADDR_W'(REG_ENABLE);   req_wdata = cfg_enable; end
                ST_WR_MASK: begin req = 1'b1; req_addr = ADDR_W'(REG_IRQ_MASK); req_wdata = mask_reg;   end
                ST_WR_POL:  begin req = 1'b1; req_addr = ADDR_W'(REG_IRQ_POL);  req_wdata = pol_reg;    end
                ST_RD_DATA: begin req = 1'b1; req_rw = 1'b0; req_addr = ADDR_W'(REG_DATA); end
                ST_WR_ACK:  begin req = 1'b1; req_addr = ADDR_W'(REG_IRQ_ACK);  end
                default:    req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            mask_reg        <= '0;
            pol_reg         <= '0;
            evt_data_reg    <= '0;
            evt_valid_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            stop_pend_reg   <= 1'b0;
            guard_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            evt_valid_reg <= (state_next == ST_EVT_OUT);
            if (state_reg == ST_IDLE && cfg_start) begin
                mask_reg        <= cfg_mask;
                pol_reg         <= cfg_pol;
                err_timeout_reg <= 1'b0;
            end else if (x_timeout) begin
                err_timeout_reg <= 1'b1;
            end
            if (state_reg == ST_RD_DATA && x_done)
                evt_data_reg <= x_rdata;
            if (state_next == ST_IDLE)
                stop_pend_reg <= 1'b0;
            else if (cfg_stop && (is_bus_state(state_reg) || state_reg == ST_GUARD))
                stop_pend_reg <= 1'b1;
            guard_cnt_reg <= (state_reg == ST_GUARD) ? guard_cnt_reg + 1'b1 : '0;
        end
    end

    avm_xfer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) u_xfer (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .rw              (req_rw),
        .addr            (req_addr),
        .wdata           (req_wdata),
        .done            (x_done),
        .rdata           (x_rdata),
        .timeout         (x_timeout),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    assign evt_valid   = evt_valid_reg;
    assign evt_data    = evt_data_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_gpio_irq_master.sv
// Self-checking bench for gpio_irq_master with a behavioural GPIO responder.
module tb_gpio_irq_master;

    logic        clk = 1'b0;
    logic        reset, cfg_start, cfg_stop;
    logic [31:0] cfg_enable, cfg_mask, cfg_pol;
    logic [4:0]  avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;
    logic        irq_i, evt_valid, evt_ready, busy, err_timeout;
    logic [31:0] evt_data;

    gpio_irq_master #(.DATA_W(32), .ADDR_W(5), .TMO_W(4)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_enable(cfg_enable), .cfg_mask(cfg_mask), .cfg_pol(cfg_pol),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .irq_i(irq_i),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
        int          ncyc;
    } xfer_t;

    typedef struct {
        logic [31:0] en, mask, pol, word;
        int          stall;
        logic [31:0] exp_evt;
    } vec_t;

    int          vectors = 0, miscompares = 0, cyc = 0;
    xfer_t       obs_q[$];
    // responder controls and observations
    logic        stall_any = 1'b1, stall_forever = 1'b0, rand_mode = 1'b0;
    logic [4:0]  stall_addr = '0;
    int          stall_n = 0;
    logic [31:0] gpio_word = '0, reg_en = '0;
    int          overlap_cnt = 0, unstable_cnt = 0, aborted_len = 0;
    logic        in_xfer = 1'b0, hold_we = 1'b0;
    logic [4:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;
    int          stall_left = 0, xfer_cycles = 0;
    int          last_cyc = 0, last_ncyc = 0;

    always @(posedge clk) cyc++;

    // Avalon responder: decides waitrequest/readdata for the current cycle
    // and logs every accepted transfer.
    always @(negedge clk) begin
        if (reset) begin
            in_xfer = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0; reg_en = '0;
        end else if (avm_read || avm_write) begin
            if (avm_read && avm_write) overlap_cnt++;
            if (!in_xfer) begin
                in_xfer = 1'b1; xfer_cycles = 0;
                hold_addr = avm_address; hold_data = avm_writedata; hold_we = avm_write;
                if (rand_mode) stall_left = int'($urandom_range(0, 3));
                else if (stall_any || avm_address == stall_addr) stall_left = stall_n;
                else stall_left = 0;
            end else if (avm_address !== hold_addr || avm_writedata !== hold_data || avm_write !== hold_we) begin
                unstable_cnt++;
            end
            xfer_cycles++;
            if (stall_forever || stall_left > 0) begin
                avm_waitrequest = 1'b1;
                if (stall_left > 0) stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = (avm_address == 5'd0) ? (gpio_word & reg_en) : 32'h0;
                if (avm_write && avm_address == 5'd4) reg_en = avm_writedata;
                obs_q.push_back('{avm_write, avm_address,
                                  avm_write ? avm_writedata : avm_readdata, cyc, xfer_cycles});
                in_xfer = 1'b0;
            end
        end else begin
            if (in_xfer) aborted_len = xfer_cycles;
            in_xfer = 1'b0; avm_waitrequest = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    task automatic expect_xfer(string nm, logic we, logic [4:0] a, logic [31:0] d);
        xfer_t x;
        int n = 0;
        while (obs_q.size() == 0 && n < 200) begin step(); n++; end
        vectors++;
        if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no transfer seen, expected %s addr %0d", nm, we ? "write" : "read", a);
            return;
        end
        x = obs_q.pop_front();
        last_cyc = x.cyc; last_ncyc = x.ncyc;
        $display("xfer %-10s %s addr=%0d data=%h cyc=%0d len=%0d", nm, x.we ? "WR" : "RD",
                 x.addr, x.data, x.cyc, x.ncyc);
        if (x.we !== we || x.addr !== a || (we && x.data !== d)) begin
            miscompares++;
            $display("FAIL %s: got we=%0b addr=%0d data=%h, expected we=%0b addr=%0d data=%h",
                     nm, x.we, x.addr, x.data, we, a, d);
        end
    endtask

    task automatic start_cfg(logic [31:0] en, logic [31:0] m, logic [31:0] p);
        cfg_enable = en; cfg_mask = m; cfg_pol = p; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic expect_cfg(logic [31:0] en, logic [31:0] m, logic [31:0] p);
        expect_xfer("wr_enable", 1'b1, 5'd4, en);
        expect_xfer("wr_mask", 1'b1, 5'd8, m);
        expect_xfer("wr_pol", 1'b1, 5'd12, p);
    endtask

    task automatic go_idle();
        cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
        check("busy_after_stop", busy, 0);
    endtask

    task automatic wait_evt(output int at);
        int n = 0;
        while (!evt_valid && n < 100) begin step(); n++; end
        at = cyc;
        vectors++;
        if (!evt_valid) begin
            miscompares++;
            $display("FAIL evt_wait: evt_valid=%0b after %0d cycles, expected 1", evt_valid, n);
        end
    endtask

    task automatic take_event(int dly, logic [31:0] exp_d);
        for (int k = 0; k < dly; k++) begin
            check("evt_hold_valid", evt_valid, 1);
            check("evt_hold_data", evt_data, exp_d);
            step();
        end
        evt_ready = 1'b1; step(); evt_ready = 1'b0;
        check("evt_drop", evt_valid, 0);
    endtask

    // Full interrupt round from WAIT_IRQ; model: event word = gpio input & enable.
    task automatic irq_round(logic [31:0] exp_d, logic keep_irq, int dly);
        int ack_cyc, evt_cyc;
        irq_i = 1'b1;
        expect_xfer("rd_data", 1'b0, 5'd0, 32'h0);
        expect_xfer("wr_ack", 1'b1, 5'd16, 32'h0);
        ack_cyc = last_cyc;
        irq_i = keep_irq;
        wait_evt(evt_cyc);
        check("evt_latency", evt_cyc - ack_cyc, 3);
        check("evt_data", evt_data, exp_d);
        take_event(dly, exp_d);
    endtask

    initial begin
        vec_t tbl[4];
        logic [31:0] m_en, m_mask, m_pol, w;
        int n;
        tbl[0] = '{32'h0000_00FF, 32'h0000_000F, 32'h0, 32'h0000_0005, 0, 32'h0000_0005};
        tbl[1] = '{32'hFFFF_0000, 32'h0000_0001, 32'h1, 32'h1234_5678, 1, 32'h1234_0000};
        tbl[2] = '{32'h0000_FFFF, 32'h0000_0003, 32'h2, 32'hDEAD_BEEF, 2, 32'h0000_BEEF};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 0, 32'h0000_0000};

        reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; irq_i = 1'b0; evt_ready = 1'b0;
        cfg_enable = '0; cfg_mask = '0; cfg_pol = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_write", avm_write, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data", evt_data, 0);
        check("rst_err", err_timeout, 0);
        reset = 1'b0;
        step();

        // table-driven configuration + one interrupt round per row
        for (int i = 0; i < 4; i++) begin
            stall_any = 1'b1; stall_n = tbl[i].stall; gpio_word = tbl[i].word;
            start_cfg(tbl[i].en, tbl[i].mask, tbl[i].pol);
            expect_cfg(tbl[i].en, tbl[i].mask, tbl[i].pol);
            step(); step();
            check("bus_idle_wait_irq", {30'b0, avm_write, avm_read}, 0);
            check("busy_wait_irq", busy, 1);
            irq_round(tbl[i].exp_evt, 1'b0, 0);
            go_idle();
        end

        // waitrequest held 3 cycles on the mask write only
        stall_any = 1'b0; stall_addr = 5'd8; stall_n = 3;
        start_cfg(32'hF0, 32'h0F, 32'h0);
        expect_xfer("wr_enable", 1'b1, 5'd4, 32'hF0);
        expect_xfer("wr_mask", 1'b1, 5'd8, 32'h0F);
        check("mask_hold_len", last_ncyc, 4);
        expect_xfer("wr_pol", 1'b1, 5'd12, 32'h0);
        go_idle();
        step();
        check("no_duplicate", obs_q.size(), 0);
        check("stable_while_stalled", unstable_cnt, 0);

        // waitrequest stuck high on the first write -> timeout
        stall_forever = 1'b1;
        start_cfg(32'h1, 32'h2, 32'h3);
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("tmo_idle", busy, 0);
        check("tmo_stall_len", aborted_len, 15);
        check("tmo_err", err_timeout, 1);
        check("tmo_no_accept", obs_q.size(), 0);
        check("tmo_strobe_low", avm_write, 0);
        stall_forever = 1'b0; stall_n = 0;
        start_cfg(32'hFFFF_FFFF, 32'h1, 32'h0);
        check("tmo_err_cleared", err_timeout, 0);
        expect_cfg(32'hFFFF_FFFF, 32'h1, 32'h0);

        // downstream back-pressure with a persistent interrupt
        step();
        gpio_word = 32'hA5A5_00FF;
        irq_round(32'hA5A5_00FF, 1'b1, 10);
        check("no_read_while_held", obs_q.size(), 0);
        gpio_word = 32'h0000_1111;
        irq_round(32'h0000_1111, 1'b0, 0);

        // stop during a stalled ack write: ack completes, guard runs, then idle
        stall_any = 1'b0; stall_addr = 5'd16; stall_n = 4;
        irq_i = 1'b1;
        expect_xfer("rd_data", 1'b0, 5'd0, 32'h0);
        n = 0;
        while (!(avm_write && avm_address == 5'd16) && n < 20) begin step(); n++; end
        cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
        expect_xfer("wr_ack", 1'b1, 5'd16, 32'h0);
        irq_i = 1'b0;
        check("stop_ack_len", last_ncyc, 5);
        step(); check("stop_guard1_busy", busy, 1);
        step(); check("stop_guard2_busy", busy, 1);
        step(); check("stop_idle", busy, 0);
        check("stop_no_evt", evt_valid, 0);
        step(); check("stop_stays_idle", busy, 0);

        // randomized rounds against the model
        rand_mode = 1'b1;
        m_en = '0;
        for (int r = 0; r < 24; r++) begin
            if (r % 8 == 0) begin
                if (busy) go_idle();
                m_en = $urandom; m_mask = $urandom; m_pol = $urandom;
                start_cfg(m_en, m_mask, m_pol);
                expect_cfg(m_en, m_mask, m_pol);
            end
            w = $urandom;
            gpio_word = w;
            irq_round(w & m_en, 1'b0, int'($urandom_range(0, 3)));
        end
        go_idle();
        rand_mode = 1'b0;
        check("no_rw_overlap", overlap_cnt, 0);
        check("stable_all", unstable_cnt, 0);

        // reset in the middle of a stalled transfer
        stall_forever = 1'b1;
        start_cfg(32'h7, 32'h7, 32'h7);
        step(); step();
        check("mid_strobe_on", avm_write, 1);
        reset = 1'b1; step();
        check("mid_rst_write", avm_write, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0; stall_forever = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_irq_master.md
Name: gpio_irq_master

Overview:
Avalon-MM initiator that drives one prog_gpio-style register-mapped GPIO responder. On start it programs the enable, irq mask and irq polarity registers. It then services each interrupt: reads the data register, writes the acknowledge register, and hands the captured input word downstream over a valid/ready interface. It sits between a control/host block and a GPIO peripheral, so the GPIO works without a CPU.

Parameters:
- DATA_W, 32, data bus and register width
- ADDR_W, 5, byte address width; register map: 0 data, 4 enable, 8 irq_mask, 12 irq_pol, 16 irq_ack
- TMO_W, 16, width of the waitrequest timeout counter; abort after 2^TMO_W-1 stalled cycles

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; starts configuration (ignored unless IDLE)
- cfg_stop  in  1  one-cycle pulse; return to IDLE at next safe point
- cfg_enable  in  DATA_W  value written to enable register
- cfg_mask  in  DATA_W  value written to irq_mask register
- cfg_pol  in  DATA_W  value written to irq_pol register
- avm_address  out  ADDR_W  byte address
- avm_write  out  1  write strobe
- avm_read  out  1  read strobe
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data, valid in the accepting cycle (latency 0)
- avm_waitrequest  in  1  responder stall
- irq_i  in  1  level interrupt from responder
- evt_valid  out  1  captured input word available
- evt_data  out  DATA_W  captured data register value
- evt_ready  in  1  downstream accepts event
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; a transfer stalled past the limit

Behaviour:
- Reset: FSM to IDLE. avm_write, avm_read, evt_valid, err_timeout = 0. avm_address, avm_writedata, evt_data = 0. Timeout and guard counters = 0.
- Transfer rule: strobe, address and writedata are registered and held stable until the first cycle with avm_waitrequest=0. That cycle completes the transfer, and the strobe drops in the next cycle. Never assert read and write together. Read data is captured in the accepting cycle.
- FSM:
  - IDLE: on cfg_start, latch cfg_* and clear err_timeout, then go to WR_EN.
  - WR_EN (addr 4) -> WR_MASK (addr 8) -> WR_POL (addr 12) -> WAIT_IRQ.
  - WAIT_IRQ: with irq_i=1, go to RD_DATA.
  - RD_DATA (addr 0): capture readdata into evt_data, then go to WR_ACK.
  - WR_ACK (addr 16, writedata 0) -> GUARD.
  - GUARD: 2 cycles with no bus activity, so the responder's registered ack clears irq before irq_i is re-sampled. Then go to EVT_OUT.
  - EVT_OUT: evt_valid=1 with evt_data stable until evt_ready=1. Then go to WAIT_IRQ, dropping evt_valid in the next cycle.
- Back-to-back events: two WAIT_IRQ-to-EVT_OUT round trips are at least 6 cycles apart with zero wait states (RD, WR, 2 guard, EVT, WAIT). The responder re-raises irq_i if the condition persists, producing a new event each round.
- Timeout: count cycles that a strobe is held with waitrequest=1; the counter clears on each accept. On reaching all-ones:
  - drop the strobe next cycle and set err_timeout;
  - go to IDLE, discarding any pending event.
- cfg_stop:
  - in IDLE, ignored;
  - in WAIT_IRQ or EVT_OUT, go to IDLE next cycle and drop evt_valid;
  - during a bus transfer or GUARD, latch a stop request. Act on it when the transfer completes and GUARD expires, so a transfer is never truncated.
- Simultaneous events:
  - cfg_start in a non-IDLE state is ignored;
  - cfg_stop and cfg_start together in IDLE: start wins;
  - irq_i falling during RD_DATA does not abort the round.
- Reset mid-transfer: strobes drop immediately at the reset edge; no completion is required.

Decomposition:
- gpio_pkg:
  - register offset constants REG_DATA=0, REG_ENABLE=4, REG_IRQ_MASK=8, REG_IRQ_POL=12, REG_IRQ_ACK=16;
  - state enum typedef master_state_t;
  - GUARD_CYCLES=2.
- One sub-module, avm_xfer: a single-transfer engine. Inputs are request, rw, address and data; outputs are done, rdata and timeout. It owns the strobe holding and the timeout counter.
- The top-level file holds the FSM and the event register.

Test Plan:
1. Zero waitstates: cfg_start with enable=0x0000_00FF, mask=0x0F, pol=0 -> writes in order: addr 4=0xFF, addr 8=0x0F, addr 12=0; busy=1, then idle bus in WAIT_IRQ.
2. irq_i=1, readdata at addr 0=0x0000_0005 -> read of addr 0, write of addr 16; evt_valid rises 3 cycles after the ack is accepted; evt_data=0x5.
3. waitrequest held 3 cycles on the WR_MASK write -> address 8 and data 0x0F stay stable for all 4 cycles; one write accepted; no duplicate.
4. TMO_W=4, waitrequest stuck high on WR_EN -> strobe drops after 15 stalled cycles; err_timeout=1; state IDLE; a new cfg_start clears err_timeout.
5. evt_ready low for 10 cycles with irq_i still high -> evt_valid and evt_data held; no new bus read until the handshake completes.
6. cfg_stop pulsed during the WR_ACK stall -> ack write completes, GUARD runs, then IDLE; evt_valid never asserts; busy=0.
